// File: rtl/fetch_pc_unit.sv
// IF stage: owns the PC, fetches from instruction memory and loads the IF/ID register.
// Redirects on taken branches from EX, honours stall and halt, counts taken branches.
module fetch_pc_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               TakeBran,
    input  logic [ADDR_W-1:0]  BranTarget,
    input  logic               Stall,
    input  logic               Halt,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [INSTR_W-1:0] IfIdInstr,
    output logic [ADDR_W-1:0]  IfIdPC,
    output logic               IfIdValid,
    output logic               FlushIdEx,
    output logic               Halted,
    output logic [15:0]        TakenCnt
);

    // state   | meaning
    // S_BOOT  | first cycle after reset, PC held, IF/ID invalid
    // S_RUN   | normal fetch, branch redirect and stall handling
    // S_HALTED| fetch frozen until reset
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [15:0]          taken_cnt_q, taken_cnt_d;
    logic [ADDR_W-1:0]    pc_inc;

    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        taken_cnt_d  = taken_cnt_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (Halt) begin
                    ifid_instr_d = NOP;
                    ifid_pc_d    = '0;
                    ifid_valid_d = 1'b0;
                    state_d      = S_HALTED;
                end else if (TakeBran) begin
                    // Redirect beats stall: the stalled instruction is wrong-path anyway.
                    pc_d         = BranTarget;
                    ifid_instr_d = NOP;
                    ifid_pc_d    = '0;
                    ifid_valid_d = 1'b0;
                    if (taken_cnt_q != 16'hFFFF) begin
                        taken_cnt_d = taken_cnt_q + 16'd1;
                    end
                end else if (!Stall) begin
                    pc_d         = pc_inc;
                    ifid_instr_d = IMemData;
                    ifid_pc_d    = pc_inc;
                    ifid_valid_d = 1'b1;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    // Reset is synchronous, so gate the status outputs while rst_n is low.
    assign FlushIdEx = rst_n & TakeBran & (state_q == S_RUN) & ~Halt;
    assign Halted    = rst_n & (state_q == S_HALTED);
    assign IMemAddr  = pc_q;
    assign IfIdInstr = ifid_instr_q;
    assign IfIdPC    = ifid_pc_q;
    assign IfIdValid = ifid_valid_q;
    assign TakenCnt  = taken_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected register contents are queued when
// stimulus is driven and popped/compared one edge later.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        TakeBran;
    logic [15:0] BranTarget;
    logic        Stall;
    logic        Halt;
    logic [15:0] IMemAddr;
    logic [15:0] IMemData;
    logic [15:0] IfIdInstr;
    logic [15:0] IfIdPC;
    logic        IfIdValid;
    logic        FlushIdEx;
    logic        Halted;
    logic [15:0] TakenCnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] ifpc;
        logic        valid;
        logic [15:0] cnt;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    assign IMemData = mem(IMemAddr);

    fetch_pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .TakeBran  (TakeBran),
        .BranTarget(BranTarget),
        .Stall     (Stall),
        .Halt      (Halt),
        .IMemAddr  (IMemAddr),
        .IMemData  (IMemData),
        .IfIdInstr (IfIdInstr),
        .IfIdPC    (IfIdPC),
        .IfIdValid (IfIdValid),
        .FlushIdEx (FlushIdEx),
        .Halted    (Halted),
        .TakenCnt  (TakenCnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational checks, sampled mid-cycle after inputs settle.
    task automatic comb_chk(input string tag, input logic flush, input logic halted);
        #1;
        chk({tag, ".flush"}, {15'd0, FlushIdEx}, {15'd0, flush});
        chk({tag, ".halted"}, {15'd0, Halted}, {15'd0, halted});
    endtask

    // Queue what the next edge must produce, take the edge, then compare.
    task automatic step(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                        input logic [15:0] ifpc, input logic valid, input logic [15:0] cnt,
                        input logic halted);
        exp_t e;
        e.tag = tag; e.pc = pc; e.instr = instr; e.ifpc = ifpc;
        e.valid = valid; e.cnt = cnt; e.halted = halted;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".pc"},     IMemAddr, e.pc);
            chk({e.tag, ".instr"},  IfIdInstr, e.instr);
            chk({e.tag, ".ifpc"},   IfIdPC, e.ifpc);
            chk({e.tag, ".valid"},  {15'd0, IfIdValid}, {15'd0, e.valid});
            chk({e.tag, ".cnt"},    TakenCnt, e.cnt);
            chk({e.tag, ".halted"}, {15'd0, Halted}, {15'd0, e.halted});
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; TakeBran = 1'b0; BranTarget = '0; Stall = 1'b0; Halt = 1'b0;

        // Reset, including a branch request that must not flush during reset
        step("reset0", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        TakeBran = 1'b1; BranTarget = 16'h0099;
        comb_chk("reset_flush", 1'b0, 1'b0);
        step("reset1", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        TakeBran = 1'b0;

        // Boot then sequential fetch up to PC=5
        rst_n = 1'b1;
        step("boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("seq%0d", k), 16'(k + 1), mem(16'(k)), 16'(k + 1), 1'b1, 16'd0, 1'b0);
        end

        // Taken branch at PC=5 to 0x40
        TakeBran = 1'b1; BranTarget = 16'h0040;
        comb_chk("br40", 1'b1, 1'b0);
        step("br40_e1", 16'h0040, 16'h0000, 16'h0000, 1'b0, 16'd1, 1'b0);
        TakeBran = 1'b0;
        comb_chk("br40_off", 1'b0, 1'b0);
        step("br40_e2", 16'h0041, mem(16'h0040), 16'h0041, 1'b1, 16'd1, 1'b0);

        // Get to PC=8, then stall three cycles
        TakeBran = 1'b1; BranTarget = 16'h0007;
        step("br07", 16'h0007, 16'h0000, 16'h0000, 1'b0, 16'd2, 1'b0);
        TakeBran = 1'b0;
        step("to8", 16'h0008, mem(16'h0007), 16'h0008, 1'b1, 16'd2, 1'b0);
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step($sformatf("stall%0d", k), 16'h0008, mem(16'h0007), 16'h0008, 1'b1, 16'd2, 1'b0);
        end
        TakeBran = 1'b1; BranTarget = 16'h0020;
        comb_chk("stall_br", 1'b1, 1'b0);
        step("stall_br", 16'h0020, 16'h0000, 16'h0000, 1'b0, 16'd3, 1'b0);
        Stall = 1'b0;

        // PC wrap at all-ones
        BranTarget = 16'hFFFF;
        step("brFFFF", 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'd4, 1'b0);
        TakeBran = 1'b0;
        step("wrap", 16'h0000, mem(16'hFFFF), 16'h0000, 1'b1, 16'd4, 1'b0);

        // Counter saturation: 65531 more branches bring the count to 16'hFFFF
        TakeBran = 1'b1; BranTarget = 16'h0100;
        repeat (65530) @(posedge clk);
        #1;
        step("sat_reach", 16'h0100, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        step("sat_hold1", 16'h0100, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        step("sat_hold2", 16'h0100, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
        TakeBran = 1'b0;
        step("sat_run", 16'h0101, mem(16'h0100), 16'h0101, 1'b1, 16'hFFFF, 1'b0);

        // Reset mid-operation, then branch during BOOT is ignored
        rst_n = 1'b0;
        step("rst_mid", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        rst_n = 1'b1; TakeBran = 1'b1; BranTarget = 16'h0077;
        comb_chk("boot_br", 1'b0, 1'b0);
        step("boot_br", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        TakeBran = 1'b0;
        step("run1", 16'h0001, mem(16'h0000), 16'h0001, 1'b1, 16'd0, 1'b0);
        TakeBran = 1'b1; BranTarget = 16'h0030;
        step("br30", 16'h0030, 16'h0000, 16'h0000, 1'b0, 16'd1, 1'b0);
        TakeBran = 1'b0;
        step("run31", 16'h0031, mem(16'h0030), 16'h0031, 1'b1, 16'd1, 1'b0);

        // Halt with simultaneous branch: halt wins, no flush, no count
        Halt = 1'b1; TakeBran = 1'b1; BranTarget = 16'h0055;
        comb_chk("halt_br", 1'b0, 1'b0);
        step("halt", 16'h0031, 16'h0000, 16'h0000, 1'b0, 16'd1, 1'b1);
        Halt = 1'b0; BranTarget = 16'h0066;
        comb_chk("halted_br", 1'b0, 1'b1);
        step("halted_br", 16'h0031, 16'h0000, 16'h0000, 1'b0, 16'd1, 1'b1);
        TakeBran = 1'b0;
        step("halted_run", 16'h0031, 16'h0000, 16'h0000, 1'b0, 16'd1, 1'b1);

        // Reset out of HALTED
        rst_n = 1'b0;
        comb_chk("halt_rst", 1'b0, 1'b0);
        step("halt_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        rst_n = 1'b1;
        step("reboot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd0, 1'b0);
        step("rerun", 16'h0001, mem(16'h0000), 16'h0001, 1'b1, 16'd0, 1'b0);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
